// File: rtl/ff_lib_pkg.sv
// Shared flip-flop library definitions.
//   ff_mode_e : run-time flip-flop personality selected by the 2-bit mode input
//   ff_op_e   : per-bit {a,b} operation code for the JK and SR personalities
package ff_lib_pkg;

  typedef enum logic [1:0] {
    FF_MODE_D  = 2'b00,
    FF_MODE_T  = 2'b01,
    FF_MODE_JK = 2'b10,
    FF_MODE_SR = 2'b11
  } ff_mode_e;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } ff_op_e;

endpackage

// File: rtl/ff_bit_cell.sv
// Combinational next-state logic for one flip-flop bit.
//   mode    in  2  flip-flop personality (D, T, JK, SR)
//   a       in  1  D / T / J / S operand
//   b       in  1  K / R operand (unused in D and T)
//   q       in  1  current bit state
//   q_next  out 1  next bit state
//   illegal out 1  SR personality with S=R=1 on this bit
module ff_bit_cell
  import ff_lib_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_next,
  output logic       illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    case (ff_mode_e'(mode))
      FF_MODE_D: q_next = a;
      FF_MODE_T: q_next = q ^ a;
      FF_MODE_JK, FF_MODE_SR: begin
        case (ff_op_e'({a, b}))
          HOLD:   q_next = q;
          RESET:  q_next = 1'b0;
          SET:    q_next = 1'b1;
          TOGGLE: begin
            // SR with S=R=1 keeps the bit at its old value and flags it.
            if (ff_mode_e'(mode) == FF_MODE_JK) q_next = ~q;
            else                                illegal = 1'b1;
          end
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/multi_ff_reg.sv
// WIDTH-bit register bank where every bit behaves as a D, T, JK or SR
// flip-flop selected at run time, with clock enable, per-bit change flags
// and a sticky error plus saturating counter for SR S=R=1 events.
//   clk         in  1          rising-edge clock
//   rst         in  1          synchronous active-high reset
//   en          in  1          update enable; 0 holds q
//   mode        in  2          00 D, 01 T, 10 JK, 11 SR
//   a           in  WIDTH      D / T / J / S operand
//   b           in  WIDTH      K / R operand
//   err_clr     in  1          clear sr_err and sr_err_cnt
//   q           out WIDTH      register state
//   chg         out WIDTH      bits of q changed by the last update edge
//   sr_err      out 1          sticky SR-illegal flag
//   sr_err_cnt  out ERR_CNT_W  saturating count of cycles with an SR-illegal bit
module multi_ff_reg
  import ff_lib_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RST_VAL   = '0,
  parameter int unsigned       ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     chg,
  output logic                 sr_err,
  output logic [ERR_CNT_W-1:0] sr_err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic             sr_event;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_bit_cell u_cell (
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .q_next  (q_next[i]),
      .illegal (illegal[i])
    );
  end

  // One event per cycle regardless of how many bits are illegal.
  assign sr_event = en && (|illegal);

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= RST_VAL;
      chg        <= '0;
      sr_err     <= 1'b0;
      sr_err_cnt <= '0;
    end else begin
      if (en) begin
        q   <= q_next;
        chg <= q_next ^ q;
      end else begin
        chg <= '0;
      end

      // An event in the same cycle as err_clr wins and restarts the count at 1.
      if (sr_event) begin
        sr_err <= 1'b1;
        if (err_clr)                  sr_err_cnt <= CNT_ONE;
        else if (sr_err_cnt != CNT_MAX) sr_err_cnt <= sr_err_cnt + CNT_ONE;
      end else if (err_clr) begin
        sr_err     <= 1'b0;
        sr_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_ff_reg.sv
// Scoreboard bench for multi_ff_reg: stimulus pushes model predictions into
// a queue, a monitor pops one per clock edge and compares.
module tb_multi_ff_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  q;
  logic [W-1:0]  chg;
  logic          sr_err;
  logic [CW-1:0] sr_err_cnt;

  multi_ff_reg #(.WIDTH(W), .RST_VAL(8'h00), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .err_clr    (err_clr),
    .q          (q),
    .chg        (chg),
    .sr_err     (sr_err),
    .sr_err_cnt (sr_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  chg;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [W-1:0] m_q;
  logic [W-1:0] m_chg;
  logic         m_err;
  int           m_cnt;

  // Drive one cycle of inputs at the falling edge and predict the result.
  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic clr);
    logic [W-1:0] nq;
    logic         ev;
    exp_t         x;
    @(negedge clk);
    rst = r; en = e; mode = md; a = av; b = bv; err_clr = clr;
    if (r) begin
      m_q = '0; m_chg = '0; m_err = 1'b0; m_cnt = 0;
    end else begin
      case (md)
        2'b00:   nq = av;
        2'b01:   nq = m_q ^ av;
        2'b10:   nq = (av & ~m_q) | (~bv & m_q);                 // JK characteristic
        default: nq = (av & ~bv) | (m_q & ~(bv & ~av));          // set / clear, else keep
      endcase
      ev = e && (md == 2'b11) && ((av & bv) != '0);
      if (e) begin
        m_chg = nq ^ m_q;
        m_q   = nq;
      end else begin
        m_chg = '0;
      end
      if (ev) begin
        m_err = 1'b1;
        m_cnt = clr ? 1 : ((m_cnt + 1 > 15) ? 15 : m_cnt + 1);
      end else if (clr) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
    end
    x.q = m_q; x.chg = m_chg; x.err = m_err; x.cnt = CW'(m_cnt);
    expq.push_back(x);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: every update edge produces one observable result.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      cmp("q",          int'(q),          int'(x.q));
      cmp("chg",        int'(chg),        int'(x.chg));
      cmp("sr_err",     int'(sr_err),     int'(x.err));
      cmp("sr_err_cnt", int'(sr_err_cnt), int'(x.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_q = '0; m_chg = '0; m_err = 1'b0; m_cnt = 0;
    // 1: reset over a loaded value while other inputs request an update
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    step(0, 1, 2'b00, 8'hA5, 8'h00, 0);
    step(1, 1, 2'b00, 8'hFF, 8'h00, 0);
    // 2: D load, then hold with en=0
    step(0, 1, 2'b00, 8'h3C, 8'h00, 0);
    step(0, 0, 2'b00, 8'hFF, 8'h00, 0);
    // 3: T toggling twice returns to start
    step(0, 1, 2'b01, 8'h0F, 8'h00, 0);
    step(0, 1, 2'b01, 8'h0F, 8'h00, 0);
    // 4: JK all four ops
    step(0, 1, 2'b00, 8'hF0, 8'h00, 0);
    step(0, 1, 2'b10, 8'hCC, 8'hAA, 0);
    // 5: SR with one illegal bit, held long enough to saturate
    step(0, 1, 2'b00, 8'h0F, 8'h00, 0);
    for (int unsigned i = 0; i < 21; i++) step(0, 1, 2'b11, 8'h81, 8'h01, 0);
    // SR illegal with en=0 must not count
    step(0, 0, 2'b11, 8'h81, 8'h01, 0);
    // 6: clear collides with event, then plain clear
    step(0, 1, 2'b11, 8'h81, 8'h01, 1);
    step(0, 1, 2'b00, 8'h00, 8'h00, 1);
    // err_clr honoured while en=0
    step(0, 1, 2'b11, 8'hFF, 8'hFF, 0);
    step(0, 0, 2'b00, 8'h00, 8'h00, 1);
    // Mode rotating every cycle with random operands
    for (int unsigned i = 0; i < 300; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) != 0),
           2'(i % 4), 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    // Fully random mode sequence, reset mid-operation included
    for (int unsigned i = 0; i < 300; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) != 0),
           2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
